// File: rtl/seq_pkg.sv
// seq_pkg: state codes, opcodes and bus/enable bit indices for instr_sequencer
package seq_pkg;
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    FETCH = 4'd1,
    LOADI = 4'd2,
    T1    = 4'd3,
    T2    = 4'd4,
    T3    = 4'd5
  } state_t;
  typedef enum logic [1:0] {
    OP_MV  = 2'b00,
    OP_MVI = 2'b01,
    OP_ADD = 2'b10,
    OP_XOR = 2'b11
  } opcode_t;
  localparam int ROUT_G   = 8;
  localparam int ROUT_EXT = 9;
  localparam int ROUT_ROM = 10;
  localparam int REN_G    = 8;
  localparam int REN_A    = 9;
  localparam int REN_ISR  = 10;
  localparam int REN_PCR  = 11;
endpackage

// File: rtl/regsel_decoder.sv
// regsel_decoder: 3-bit register index to 8-bit one-hot select
module regsel_decoder (
  input  logic [2:0] sel,
  output logic [7:0] onehot
);
  assign onehot = 8'b1 << sel;
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: control FSM for mv/mvi/add/xor; SEQ_SINGLE_STEP_EN adds a step input
module instr_sequencer
  import seq_pkg::*;
(
  input  logic        clock,
  input  logic        resetnot,
  input  logic        run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [15:0] q_rom,
  input  logic [15:0] isr,
  output logic [15:0] rout,
  output logic [15:0] ren,
  output logic        addxor,
  output logic        increment,
  output logic        done,
  output logic [3:0]  currstate,
  output logic [3:0]  nextstate
);
  state_t st, ns;
  opcode_t op;
  logic [7:0] rx_oh, ry_oh;
  logic start, cont, unused_ok;
  assign op = opcode_t'(isr[15:14]);
  assign unused_ok = ^{q_rom, isr[7:0]};
  regsel_decoder u_rx (.sel(isr[13:11]), .onehot(rx_oh));
  regsel_decoder u_ry (.sel(isr[10:8]),  .onehot(ry_oh));
`ifdef SEQ_SINGLE_STEP_EN
  logic run_q;
  always_ff @(posedge clock or negedge resetnot)
    if (!resetnot) run_q <= 1'b0;
    else run_q <= run;
  assign start = step ? run & ~run_q : run;
  assign cont  = run & ~step;
`else
  assign start = run;
  assign cont  = run;
`endif
  always_ff @(posedge clock or negedge resetnot)
    if (!resetnot) st <= IDLE;
    else st <= ns;
  always_comb begin
    rout = '0;
    ren = '0;
    addxor = 1'b0;
    increment = 1'b0;
    done = 1'b0;
    ns = IDLE;
    case (st)
      IDLE: ns = start ? FETCH : IDLE;
      FETCH: begin
        increment = 1'b1;
        ns = LOADI;
      end
      LOADI: begin
        rout[ROUT_ROM] = 1'b1;
        ren[REN_ISR] = 1'b1;
        ns = T1;
      end
      T1: case (op)
        OP_MV: begin
          rout[7:0] = ry_oh;
          ren[7:0] = rx_oh;
          done = 1'b1;
        end
        OP_MVI: begin
          rout[ROUT_ROM] = 1'b1;
          ren[7:0] = rx_oh;
          increment = 1'b1;
          done = 1'b1;
        end
        default: begin
          rout[7:0] = rx_oh;
          ren[REN_A] = 1'b1;
          ns = T2;
        end
      endcase
      T2: begin
        rout[7:0] = ry_oh;
        ren[REN_G] = 1'b1;
        addxor = isr[14];
        ns = T3;
      end
      T3: begin
        rout[ROUT_G] = 1'b1;
        ren[7:0] = rx_oh;
        done = 1'b1;
      end
      default: ns = IDLE;
    endcase
    if (done) ns = cont ? FETCH : IDLE;
  end
  assign currstate = st;
  // nextstate is forced to IDLE while reset is held so every output reads 0
  assign nextstate = resetnot ? ns : IDLE;
endmodule
